// File: rtl/uart_tx_pkg.sv
// Shared types, parity encodings and helpers for the UART transmit engine.
// The BREAK/BRK_MARK states exist only when UART_TX_BREAK_EN is defined.
package uart_tx_pkg;

    localparam int MIN_BITS = 5;

    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_EVEN  = 3'd1;
    localparam logic [2:0] PAR_ODD   = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
`ifdef UART_TX_BREAK_EN
        ,
        ST_BREAK,
        ST_BRK_MARK
`endif
    } state_e;

    function automatic logic [3:0] clamp_bits(input logic [3:0] req, input int max_bits);
        logic [3:0] res;
        res = req;
        if (req < 4'(MIN_BITS)) begin
            res = 4'(MIN_BITS);
        end else if (int'(req) > max_bits) begin
            res = 4'(max_bits);
        end
        return res;
    endfunction

    // Encodings 5-7 fall through to "no parity bit".
    function automatic logic parity_en(input logic [2:0] mode);
        return mode inside {PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE};
    endfunction

    function automatic logic parity_bit(input logic [2:0] mode, input logic acc);
        logic res;
        case (mode)
            PAR_EVEN: res = acc;
            PAR_ODD:  res = ~acc;
            PAR_MARK: res = 1'b1;
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX buffer: push/pop with registered full, empty, level and overflow.
// DEPTH is a power of two, or 1 for a single holding register.
module uart_tx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             overflow_q, overflow_d;
    logic             push_ok;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        do_pop     = pop && !empty_q;
        push_ok    = push && (!full_q || do_pop);
        wr_ptr_d   = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        level_d    = level_q;
        case ({push_ok, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        full_d     = (level_d == LW'(DEPTH));
        empty_d    = (level_d == '0);
        overflow_d = push && !push_ok;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone mark which
    // entries are valid, and an unreset array can map onto RAM.
    // A push into a full buffer that pops in the same cycle reuses the slot
    // being read, which still returns its old word this cycle.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: buffered words serialised as start/data/parity/stop frames.
// Define UART_TX_BREAK_EN to add the break_req port and line-break states.
module uart_tx_engine
    import uart_tx_pkg::*;
#(
    parameter int MAX_BITS   = 9,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          xmit_pulse,
    input  logic                          wr_en,
    input  logic [MAX_BITS-1:0]           wr_data,
    input  logic [3:0]                    num_bits,
    input  logic [2:0]                    parity_mode,
    input  logic                          stop2,
`ifdef UART_TX_BREAK_EN
    input  logic                          break_req,
`endif
    output logic                          tx,
    output logic                          busy,
    output logic                          txrdy,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    state_e              state_q, state_d;
    logic [MAX_BITS-1:0] shift_q, shift_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [3:0]          nbits_q, nbits_d;
    logic [2:0]          pmode_q, pmode_d;
    logic                stop2_q, stop2_d;
    logic                stop_cnt_q, stop_cnt_d;
    logic                par_acc_q, par_acc_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;

    logic                pop;
    logic                break_start;
    logic                fifo_full;
    logic                fifo_empty;
    logic [MAX_BITS-1:0] fifo_head;

    uart_tx_fifo #(
        .WIDTH (MAX_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .overflow  (overflow)
    );

`ifdef UART_TX_BREAK_EN
    assign break_start = (state_q == ST_IDLE) && xmit_pulse && break_req;
`else
    assign break_start = 1'b0;
`endif

    // A pending break outranks a queued word, so the word stays in the buffer.
    assign pop = (state_q == ST_IDLE) && !fifo_empty && !break_start;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        nbits_d    = nbits_q;
        pmode_d    = pmode_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        par_acc_d  = par_acc_q;
        tx_d       = tx_q;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
`ifdef UART_TX_BREAK_EN
                if (break_start) begin
                    tx_d    = 1'b0;
                    state_d = ST_BREAK;
                end else
`endif
                if (pop) begin
                    shift_d = fifo_head;
                    nbits_d = clamp_bits(num_bits, MAX_BITS);
                    pmode_d = parity_en(parity_mode) ? parity_mode : PAR_NONE;
                    stop2_d = stop2;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                par_acc_d = 1'b0;
                if (xmit_pulse) begin
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (xmit_pulse) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = 4'd1;
                    par_acc_d = par_acc_q ^ shift_q[0];
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xmit_pulse) begin
                    if (bit_cnt_q < nbits_q) begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        par_acc_d = par_acc_q ^ shift_q[0];
                    end else if (pmode_q != PAR_NONE) begin
                        tx_d    = parity_bit(pmode_q, par_acc_q);
                        state_d = ST_PARITY;
                    end else begin
                        tx_d       = 1'b1;
                        stop_cnt_d = stop2_q;
                        state_d    = ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (xmit_pulse) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = stop2_q;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                // The pulse that raised tx opened the first stop bit; the
                // next start bit follows the next pulse once IDLE has popped.
                if (!stop_cnt_q) begin
                    state_d = ST_IDLE;
                end else if (xmit_pulse) begin
                    stop_cnt_d = 1'b0;
                end
            end
`ifdef UART_TX_BREAK_EN
            ST_BREAK: begin
                if (xmit_pulse && !break_req) begin
                    tx_d    = 1'b1;
                    state_d = ST_BRK_MARK;
                end
            end
            ST_BRK_MARK: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            nbits_q    <= 4'(MIN_BITS);
            pmode_q    <= PAR_NONE;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            par_acc_q  <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            nbits_q    <= nbits_d;
            pmode_q    <= pmode_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            par_acc_q  <= par_acc_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign tx    = tx_q;
    assign busy  = busy_q;
    assign txrdy = !fifo_full;
    assign empty = fifo_empty;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: frame vectors, FIFO full/overflow, reset, break.
module tb_uart_tx_engine;
    import uart_tx_pkg::*;

    localparam int MAX_BITS   = 9;
    localparam int FIFO_DEPTH = 4;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                xmit_pulse = 1'b0;
    logic                wr_en = 1'b0;
    logic [MAX_BITS-1:0] wr_data = '0;
    logic [3:0]          num_bits = 4'd8;
    logic [2:0]          parity_mode = PAR_NONE;
    logic                stop2 = 1'b0;
`ifdef UART_TX_BREAK_EN
    logic                break_req = 1'b0;
`endif
    logic                tx;
    logic                busy;
    logic                txrdy;
    logic                empty;
    logic [LW-1:0]       fifo_level;
    logic                overflow;

    int total = 0;
    int bad = 0;
    int ovf_cnt = 0;
    int ovf_base;

    uart_tx_engine #(
        .MAX_BITS   (MAX_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .xmit_pulse  (xmit_pulse),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .num_bits    (num_bits),
        .parity_mode (parity_mode),
        .stop2       (stop2),
`ifdef UART_TX_BREAK_EN
        .break_req   (break_req),
`endif
        .tx          (tx),
        .busy        (busy),
        .txrdy       (txrdy),
        .empty       (empty),
        .fifo_level  (fifo_level),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overflow) ovf_cnt++;
    end

    typedef struct {
        logic [8:0] data;
        logic [3:0] nbits;
        logic [2:0] pmode;
        logic       stop2;
        string      frame;   // expected tx per bit period, first period first
    } vec_t;

    vec_t vec [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        xmit_pulse = 1'b1;
        tick();
        xmit_pulse = 1'b0;
    endtask

    task automatic push_word(input logic [8:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    // One pulse per expected bit, tx checked right after each pulse edge.
    task automatic send_frame(input string exp, input string tag, input bit no_tail);
        for (int i = 0; i < exp.len(); i++) begin
            pulse();
            check($sformatf("%s bit%0d", tag, i), tx, (exp[i] == 8'h31));
            if (!(no_tail && i == exp.len() - 1)) begin
                repeat (3) tick();
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec[0] = '{9'h0A5, 4'd8,  PAR_NONE,  1'b0, "0101001011"};
        vec[1] = '{9'h003, 4'd7,  PAR_ODD,   1'b1, "01100000111"};
        vec[2] = '{9'h1FF, 4'd9,  PAR_MARK,  1'b0, "011111111111"};
        vec[3] = '{9'h00F, 4'd3,  PAR_EVEN,  1'b0, "01111001"};
        vec[4] = '{9'h155, 4'd12, PAR_SPACE, 1'b1, "0101010101011"};
        vec[5] = '{9'h05A, 4'd6,  3'd6,      1'b0, "00101101"};
        vec[6] = '{9'h02C, 4'd8,  PAR_EVEN,  1'b0, "00011010011"};

        // Reset state
        repeat (3) tick();
        check("rst tx", tx, 1);
        check("rst busy", busy, 0);
        check("rst txrdy", txrdy, 1);
        check("rst empty", empty, 1);
        check("rst level", fifo_level, 0);
        check("rst overflow", overflow, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) tick();
        check("idle tx", tx, 1);

        // Frame vectors; config is scrambled after latching to show it is held.
        for (int v = 0; v < 7; v++) begin
            num_bits    = vec[v].nbits;
            parity_mode = vec[v].pmode;
            stop2       = vec[v].stop2;
            push_word(vec[v].data);
            check($sformatf("v%0d level", v), fifo_level, 1);
            check($sformatf("v%0d empty", v), empty, 0);
            tick();
            check($sformatf("v%0d busy load", v), busy, 1);
            check($sformatf("v%0d popped", v), fifo_level, 0);
            check($sformatf("v%0d tx load", v), tx, 1);
            num_bits    = 4'd5;
            parity_mode = PAR_MARK;
            stop2       = ~vec[v].stop2;
            send_frame(vec[v].frame, $sformatf("v%0d", v), 1'b0);
            check($sformatf("v%0d busy end", v), busy, 0);
        end

        // FIFO full, overflow, write+pop while full, back-to-back frames
        num_bits    = 4'd8;
        parity_mode = PAR_NONE;
        stop2       = 1'b0;
        push_word(9'h011);
        tick();
        check("fifo busy", busy, 1);
        ovf_base = ovf_cnt;
        push_word(9'h022);
        push_word(9'h033);
        push_word(9'h044);
        check("fifo txrdy 3", txrdy, 1);
        push_word(9'h055);
        check("fifo txrdy 4", txrdy, 0);
        push_word(9'h066);
        check("fifo level full", fifo_level, 4);
        check("fifo overflow pulse", overflow, 1);
        tick();
        check("fifo overflow clear", overflow, 0);
        check("fifo overflow count", ovf_cnt - ovf_base, 1);
        send_frame("0100010001", "f11", 1'b1);
        tick();
        wr_data = 9'h077;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        check("fifo wr+pop level", fifo_level, 4);
        check("fifo wr+pop txrdy", txrdy, 0);
        check("fifo wr+pop overflow", overflow, 0);
        check("fifo wr+pop busy", busy, 1);
        tick();
        send_frame("0010001001", "f22", 1'b0);
        send_frame("0110011001", "f33", 1'b0);
        send_frame("0001000101", "f44", 1'b0);
        send_frame("0101010101", "f55", 1'b0);
        send_frame("0111011101", "f77", 1'b0);
        check("fifo drained busy", busy, 0);
        check("fifo drained empty", empty, 1);
        check("fifo drained level", fifo_level, 0);
        check("fifo drained txrdy", txrdy, 1);
        check("fifo overflow total", ovf_cnt - ovf_base, 1);

        // Asynchronous reset in the middle of DATA
        push_word(9'h000);
        push_word(9'h03C);
        pulse();
        repeat (3) tick();
        pulse();
        check("rstmid tx before", tx, 0);
        check("rstmid level before", fifo_level, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstmid tx", tx, 1);
        check("rstmid busy", busy, 0);
        check("rstmid empty", empty, 1);
        check("rstmid level", fifo_level, 0);
        check("rstmid txrdy", txrdy, 1);
        repeat (2) tick();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) tick();
        pulse();
        repeat (3) tick();
        check("rstmid after tx", tx, 1);
        check("rstmid after busy", busy, 0);

`ifdef UART_TX_BREAK_EN
        // Break held for three bit periods with a word queued behind it
        break_req = 1'b1;
        pulse();
        check("brk tx p0", tx, 0);
        check("brk busy", busy, 1);
        push_word(9'h0A5);
        tick();
        tick();
        check("brk word held", fifo_level, 1);
        pulse();
        check("brk tx p1", tx, 0);
        repeat (3) tick();
        pulse();
        check("brk tx p2", tx, 0);
        break_req = 1'b0;
        repeat (3) tick();
        pulse();
        check("brk mark tx", tx, 1);
        check("brk mark busy", busy, 1);
        repeat (3) tick();
        send_frame("0101001011", "brkf", 1'b0);
        check("brk end busy", busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
